pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Consumes the PLL lock indication in the PLL output clock domain and produces the staged, active-high system resets for the logic sniffer core.
- Synchronizes the lock signal and requires it to be stable before releasing anything.
- Releases the core reset, then the sampler reset.
- On loss of lock, re-asserts both resets and counts the event.
- Sits directly downstream of the PLL; every other block's reset comes from it.

Parameters:
STABLE_CYCLES, 16, consecutive synchronized-lock-high cycles required before the reset hold phase begins (>=1)
HOLD_CYCLES, 64, cycles both resets stay asserted after lock is declared stable (>=1)
STAGE_GAP, 8, cycles between core_reset release and sampler_reset release (>=1)
CNT_W, 8, width of lock_loss_count

Ports:
clock  input  1  PLL output clock (50 MHz); sole clock
reset  input  1  synchronous, active-high; already synchronous to clock
locked  input  1  PLL lock, asynchronous to clock
core_reset  output  1  active-high reset for the protocol/control core
sampler_reset  output  1  active-high reset for the sampler/capture path
ready  output  1  high while in RUN
lock_loss_count  output  CNT_W  number of lock losses seen in RUN, saturating

Behaviour:
- Clocking and reset: one clock. reset is synchronous and active-high, with priority over everything else. While reset is high:
  - state = WAIT_LOCK, counters = 0, sync flops = 0.
  - core_reset = 1, sampler_reset = 1, ready = 0, lock_loss_count = 0.
- locked passes through a 2-flop synchronizer; the result is locked_s. No other logic samples locked directly.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state transition.
- FSM states and transitions (cnt is one shared down/up counter, cleared on every transition):
  - WAIT_LOCK: both resets = 1, ready = 0. locked_s = 1 -> STABLE, cnt = 0.
  - STABLE: both resets = 1. Each locked_s = 1 cycle: if cnt == STABLE_CYCLES-1 -> HOLD, else cnt++.
  - HOLD: both resets = 1. Each cycle: if cnt == HOLD_CYCLES-1 -> STAGE (core_reset <= 0), else cnt++.
  - STAGE: core_reset = 0, sampler_reset = 1. If cnt == STAGE_GAP-1 -> RUN (sampler_reset <= 0, ready <= 1), else cnt++.
  - RUN: both resets = 0, ready = 1. Holds until lock loss or reset.
- Lock loss (no-filter build): locked_s = 0 in STABLE, HOLD, STAGE or RUN -> WAIT_LOCK on that edge.
  - core_reset <= 1, sampler_reset <= 1, ready <= 0 on the same edge.
  - If the source state was RUN, lock_loss_count increments; it saturates at 2^CNT_W-1.
  - Losses in STABLE, HOLD or STAGE do not count.
- Timing: let E0 be the first edge at which the first sync flop samples locked = 1, with locked held high thereafter.
  - locked_s is high after E0+1; the FSM enters STABLE at E0+2.
  - core_reset falls at edge E0+2+STABLE_CYCLES+HOLD_CYCLES.
  - sampler_reset falls and ready rises at E0+2+STABLE_CYCLES+HOLD_CYCLES+STAGE_GAP.
  - With defaults: E0+82 and E0+90.
- Invariants: sampler_reset is never 0 while core_reset is 1. ready == !sampler_reset at all times.
- Simultaneous events: reset together with lock loss -> reset behaviour, no count increment. Lock loss on the same edge a phase completes -> lock loss wins.
- reset mid-sequence or in RUN: immediate return to reset values; lock_loss_count is cleared.

Optional Feature:
LOCK_GLITCH_FILTER_EN
- Defined: a 2-bit low-run counter tracks consecutive locked_s = 0 cycles in STABLE, HOLD, STAGE and RUN.
  - Lock loss is declared only on the 4th consecutive low cycle; the transition to WAIT_LOCK and the count increment happen on that edge.
  - Dips of 1-3 cycles are ignored. During a dip in STABLE, cnt does not advance. HOLD and STAGE continue counting through a dip.
  - The low-run counter clears on any locked_s = 1 cycle and on every state transition.
- Undefined: a single low cycle of locked_s is a lock loss, as described in Behaviour.

Test Plan:
1. Reset-only: reset = 1 for 5 cycles, locked = 0 -> core_reset = 1, sampler_reset = 1, ready = 0, lock_loss_count = 0; outputs hold after reset drops while locked = 0.
2. Power-up, defaults: locked rises before E0 and stays high -> core_reset falls exactly at E0+82; sampler_reset falls and ready rises exactly at E0+90.
3. Early loss: locked drops for 1 cycle during HOLD (no filter) -> both resets stay 1, FSM restarts from WAIT_LOCK, lock_loss_count stays 0; release times re-measured from the new E0.
4. RUN loss and saturation, CNT_W = 2: 5 lock losses, each in RUN (locked low 3 cycles, then recover fully) -> core_reset = 1 on the edge after locked_s falls; count reads 1, 2, 3, 3, 3.
5. Glitch filter (LOCK_GLITCH_FILTER_EN defined) in RUN:
   - 3-cycle low -> ready stays 1, count stays 0.
   - 4-cycle low -> ready = 0 and count = 1 on the 4th low edge of locked_s.
6. Reset priority: in RUN, assert reset on the same edge locked_s falls -> all outputs at reset values, lock_loss_count = 0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Staged reset generator driven by PLL lock: synchronizes locked, waits for stable lock,
// then releases core_reset followed by sampler_reset. Optional macro: LOCK_GLITCH_FILTER_EN.
module pll_reset_sequencer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned STAGE_GAP     = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  output logic             core_reset,
  output logic             sampler_reset,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_count
);

  localparam int unsigned MAX_A = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > STAGE_GAP) ? MAX_A : STAGE_GAP;
  localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_HOLD,
    ST_STAGE,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        sync_q;
  logic              locked_s;
  logic              loss;
  logic              core_reset_q, sampler_reset_q, ready_q;
`ifdef LOCK_GLITCH_FILTER_EN
  logic [1:0]        low_q, low_d;
`endif

  assign locked_s = sync_q[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

`ifdef LOCK_GLITCH_FILTER_EN
  // Loss is declared only when the 4th consecutive low cycle is seen.
  assign loss = (state_q != ST_WAIT_LOCK) && !locked_s && (low_q == 2'd3);
`else
  assign loss = (state_q != ST_WAIT_LOCK) && !locked_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (locked_s) begin
          if (cnt_q == STABLE_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_STAGE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STAGE: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides any phase completion on the same edge.
    if (loss) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      if ((state_q == ST_RUN) && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

`ifdef LOCK_GLITCH_FILTER_EN
  always_comb begin
    low_d = '0;
    if ((state_d == state_q) && (state_q != ST_WAIT_LOCK) && !locked_s) begin
      low_d = low_q + 2'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_WAIT_LOCK;
      cnt_q           <= '0;
      count_q         <= '0;
      core_reset_q    <= 1'b1;
      sampler_reset_q <= 1'b1;
      ready_q         <= 1'b0;
`ifdef LOCK_GLITCH_FILTER_EN
      low_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      count_q         <= count_d;
      core_reset_q    <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                         (state_d == ST_HOLD);
      sampler_reset_q <= (state_d != ST_RUN);
      ready_q         <= (state_d == ST_RUN);
`ifdef LOCK_GLITCH_FILTER_EN
      low_q           <= low_d;
`endif
    end
  end

  assign core_reset      = core_reset_q;
  assign sampler_reset   = sampler_reset_q;
  assign ready           = ready_q;
  assign lock_loss_count = count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: elapsed-progress reference model plus
// directed scenarios with hand-computed release edges. Honours LOCK_GLITCH_FILTER_EN.
module tb_pll_reset_sequencer;

  localparam int S   = 16;
  localparam int H   = 64;
  localparam int G   = 8;
  localparam int CW  = 2;
  localparam int SHG = S + H + G;
  localparam int CMAX = (1 << CW) - 1;
`ifdef LOCK_GLITCH_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          locked = 1'b0;
  logic          core_reset, sampler_reset, ready;
  logic [CW-1:0] lock_loss_count;

  pll_reset_sequencer #(
    .STABLE_CYCLES(S),
    .HOLD_CYCLES(H),
    .STAGE_GAP(G),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .locked(locked),
    .core_reset(core_reset),
    .sampler_reset(sampler_reset),
    .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: progress = edges of sequencing since entering STABLE.
  bit m_s1 = 0, m_s2 = 0, m_active = 0;
  int m_prog = 0, m_low = 0, m_count = 0;

  always @(posedge clock) begin : model
    bit ls, act;
    int prog, low, cnt;
    ls = m_s2; act = m_active; prog = m_prog; low = m_low; cnt = m_count;
    if (reset) begin
      act = 0; prog = 0; low = 0; cnt = 0;
      m_s1 <= 1'b0;
      m_s2 <= 1'b0;
    end else begin
      m_s2 <= m_s1;
      m_s1 <= locked;
      if (!act) begin
        if (ls) begin act = 1; prog = 0; low = 0; end
      end else if (!ls && (!FILTER || low == 3)) begin
        if (prog >= SHG) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
        act = 0; prog = 0; low = 0;
      end else begin
        if (ls) low = 0; else low = low + 1;
        if (prog < SHG && (ls || prog >= S)) begin
          prog = prog + 1;
          if (prog == S || prog == S + H || prog == SHG) low = 0;
        end
      end
    end
    m_active <= act;
    m_prog   <= prog;
    m_low    <= low;
    m_count  <= cnt;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("core_reset", core_reset, !(m_active && m_prog >= S + H));
      check("sampler_reset", sampler_reset, !(m_active && m_prog >= SHG));
      check("ready", ready, (m_active && m_prog >= SHG));
      check("lock_loss_count", lock_loss_count, m_count);
      check("inv_ready", ready, !sampler_reset);
      check("inv_order", (!sampler_reset && core_reset), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // which: 0 = core_reset falls, 1 = ready rises. Returns the posedge index.
  task automatic wait_evt(input string name, input int which, output int ed);
    ed = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if ((which == 0 && core_reset === 1'b0) || (which == 1 && ready === 1'b1)) begin
        ed = cyc;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL %s: timeout waiting, got none expected event", name);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_core"}, core_reset, 1);
    check({name, "_samp"}, sampler_reset, 1);
    check({name, "_ready"}, ready, 0);
    check({name, "_count"}, lock_loss_count, 0);
  endtask

  int e0, ed, p;
  int exp_cnt [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    chk_en = 1'b1;
    tick(5);
    check_reset_vals("reset_only");
    reset = 1'b0;
    tick(5);
    check_reset_vals("unlocked_hold");

    // Power-up with defaults
    locked = 1'b1;
    e0 = cyc + 1;
    wait_evt("pwr_core", 0, ed);
    check("pwr_core_edge", ed - e0, 82);
    wait_evt("pwr_ready", 1, ed);
    check("pwr_ready_edge", ed - e0, 90);
    check("pwr_samp", sampler_reset, 0);

    // Reset while in RUN, then early 1-cycle dip during HOLD
    reset = 1'b1;
    tick(1);
    check_reset_vals("run_reset");
    reset = 1'b0;
    e0 = cyc + 1;
    tick(40);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    if (!FILTER) e0 = cyc + 1;
    wait_evt("early_core", 0, ed);
    check("early_core_edge", ed - e0, 82);
    check("early_count", lock_loss_count, 0);
    wait_evt("early_ready", 1, ed);
    check("early_ready_edge", ed - e0, 90);

`ifndef LOCK_GLITCH_FILTER_EN
    for (int k = 0; k < 5; k++) begin
      locked = 1'b0;
      p = cyc + 1;
      tick(2);
      check("loss_core_before", core_reset, 0);
      tick(1);
      check("loss_core_after", core_reset, 1);
      check("loss_count", lock_loss_count, exp_cnt[k]);
      locked = 1'b1;
      e0 = cyc + 1;
      wait_evt("loss_ready", 1, ed);
      check("loss_ready_edge", ed - e0, 90);
    end
`else
    locked = 1'b0;
    tick(3);
    locked = 1'b1;
    tick(3);
    check("glitch3_ready", ready, 1);
    check("glitch3_count", lock_loss_count, 0);
    locked = 1'b0;
    p = cyc + 1;
    tick(4);
    locked = 1'b1;
    tick(1);
    check("glitch4_ready_pre", ready, 1);
    tick(1);
    check("glitch4_ready_post", ready, 0);
    check("glitch4_count", lock_loss_count, 1);
    wait_evt("glitch4_ready", 1, ed);
    check("glitch4_ready_edge", ed - (p + 4), 90);
`endif

    // Reset on the same edge locked_s falls in RUN
    check("pre_prio_count_nonzero", (lock_loss_count != 0), 1);
    locked = 1'b0;
    p = cyc + 1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check_reset_vals("prio");
    reset  = 1'b0;
    locked = 1'b1;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
